sw_alloc: RTL and testbench
===========================

// Module: sw_alloc
// PURPOSE
//   Central switch allocator for the 4x4 wormhole switch. Replaces the four independent
//   per-output arbiters and the ack OR-reduction; drives the crossbar select matrix directly.
//   Per output port: round-robin among requesting inputs, packet lock from head to tail flit,
//   credit-based flow control toward the downstream input buffer.
//   Sits between the four input buffers (req/tail/ack) and the crossbar (grant vectors).
// PARAMETERS
//   CREDITS  4                      downstream buffer depth in flits = initial credits per output
//   CW       $clog2(CREDITS+1)      credit counter width (derived, do not override)
// PORTS
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous reset, active-high
//   req0..req3 in   4   per-input destination request, one-hot on output index, 0 = none
//   tail       in   4   tail[i]=1: flit currently at head of input i is a tail flit
//   credit_in  in   4   credit_in[o]=1: downstream of output o freed one slot this cycle
//   ack        out  4   ack[i]=1: head flit of input i is transferred (popped) this cycle
//   grant0..grant3 out 4 grant_o[i]=1: crossbar connects input i to output o this cycle, one-hot or 0
//   locked     out  4   locked[o]=1: output o is mid-packet (owned)
//   err        out  1   sticky: credit overflow or multi-hot req seen; cleared only by rst
// BEHAVIOUR
//   Reset: one clock, synchronous, active-high. While rst=1, ack, grant*, locked = 0.
//     After reset: every output IDLE, rr pointer = 0, credits = CREDITS, err = 0.
//   Timing: ack and grant are combinational from current state + req/tail/credit (0-cycle).
//     State (lock, owner, pointer, credits) updates on the clock edge after the transfer.
//   Per-output state machine, output o:
//     IDLE: cand = {req3[o],req2[o],req1[o],req0[o]}. If cand!=0 and credit[o]>0:
//       winner = first set bit scanning ptr, ptr+1, ... mod 4; grant_o[winner]=1.
//       Transfer with tail[winner]=0 -> LOCKED, owner=winner.
//       Transfer with tail[winner]=1 (single-flit packet) -> stay IDLE, ptr=winner+1 mod 4.
//       cand!=0 and credit[o]==0: no grant, ptr unchanged.
//     LOCKED: only owner may use o. grant_o[owner] = req_owner[o] && credit[o]>0.
//       Other inputs requesting o are not granted, whatever their priority.
//       Transfer with tail[owner]=1 -> IDLE, ptr=owner+1 mod 4.
//       Owner req drops mid-packet (input buffer empty): stay LOCKED, no grant, wait.
//   ack[i] = OR over o of grant_o[i]. req is one-hot, so at most one grant per input.
//   Credits, per output: grant this cycle decrements by 1; credit_in increments by 1.
//     Both in the same cycle: count unchanged.
//     credit_in at count==CREDITS with no grant: count held, err set.
//     A grant is never issued at count==0, so the counter never underflows.
//   Multi-hot req_i: err set. The lowest-indexed output is treated as the request,
//     the others as 0. Protocol violation; the bench asserts it never occurs.
//   rst mid-packet: locks and credits are discarded. Input buffers and the downstream are
//     reset by the same rst, so no recovery sequencing is needed.
// STRUCTURE
//   sw_pkg: NPORT=4, FLIT_W=10, typedef logic [NPORT-1:0] portvec_t,
//     typedef enum logic {S_IDLE, S_LOCKED} alloc_st_t.
//   Sub-module sw_alloc_out: one per output, holds state/owner/ptr/credit counter and
//     produces its grant vector. Instantiated 4x. Top: req transpose, ack OR, err logic.
// TESTING
//   1 Reset, then req0=0001 with tail0=1 -> grant0=0001, ack=0001 same cycle; next cycle ptr(o0)=1, credit(o0)=3.
//   2 req0..req3 all =0001, every flit a tail, credit_in[0] each cycle -> grant0 rotates 0001,0010,0100,1000,0001.
//   3 Input 2 sends a 3-flit packet to o1 (tail on flit 3) while input 0 also requests o1 ->
//     grant1=0100 for 3 transfers, then 0001; locked[1]=1 only between head and tail.
//   4 No credit_in, 5 single-flit packets from input 0 to o3 (CREDITS=4) -> 4 acks, then ack held 0;
//     one credit_in[3] pulse -> exactly one more ack.
//   5 Grant on o2 and credit_in[2] in the same cycle at credit=2 -> credit stays 2.
//     credit_in[2] at credit=4 with no grant -> err=1 and stays 1.
//   6 rst pulse while o1 is LOCKED to input 3 -> next cycle locked=0, credits=4, and a new head
//     from input 0 to o1 is granted immediately.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared types and helpers for the 4x4 wormhole switch allocator.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package sw_pkg;

  localparam int NPORT  = 4;
  localparam int FLIT_W = 10;
  localparam int PTR_W  = 2;

  typedef logic [NPORT-1:0] portvec_t;
  typedef logic [PTR_W-1:0] port_idx_t;

  typedef enum logic {S_IDLE, S_LOCKED} alloc_st_t;

  // First set bit of cand scanning ptr, ptr+1, ... with wrap; ptr when cand is empty.
  function automatic port_idx_t rr_pick(input portvec_t cand, input port_idx_t ptr);
    port_idx_t idx;
    port_idx_t win;
    win = ptr;
    for (int k = NPORT - 1; k >= 0; k--) begin
      idx = ptr + port_idx_t'(k);
      if (cand[idx]) win = idx;
    end
    return win;
  endfunction

  // Keeps only the lowest set bit.
  function automatic portvec_t lowest_bit(input portvec_t v);
    return v & (~v + portvec_t'(1));
  endfunction

  function automatic logic is_multi_hot(input portvec_t v);
    return (v & (v - portvec_t'(1))) != '0;
  endfunction

endpackage

// File: rtl/sw_alloc_out.sv
// One output port of the allocator: round-robin pick, head-to-tail lock, credit counter.
// Latency: grant is combinational from state + cand/tail; state updates on the next edge.
// Backpressure: no grant while credit count is zero; locked owner with no request just waits.
module sw_alloc_out
  import sw_pkg::*;
#(
  parameter int CREDITS = 4,
  localparam int CW     = $clog2(CREDITS + 1)
) (
  input  logic     clk,
  input  logic     rst,
  input  portvec_t cand,
  input  portvec_t tail,
  input  logic     credit_in,
  output portvec_t grant,
  output logic     locked,
  output logic     cred_ovf
);

  alloc_st_t state_q, state_d;
  port_idx_t owner_q, owner_d;
  port_idx_t ptr_q, ptr_d;
  logic [CW-1:0] credit_q, credit_d;

  port_idx_t winner;
  logic      xfer;
  logic      xfer_tail;

  // Grant: round-robin winner when idle, only the owner when locked; never without a credit.
  always_comb begin
    winner = rr_pick(cand, ptr_q);
    grant  = '0;
    if (!rst && credit_q != '0) begin
      if (state_q == S_IDLE) begin
        if (cand != '0) grant[winner] = 1'b1;
      end else begin
        if (cand[owner_q]) grant[owner_q] = 1'b1;
      end
    end
    xfer      = |grant;
    xfer_tail = |(grant & tail);
    locked    = (state_q == S_LOCKED) && !rst;
  end

  // Next lock/owner/pointer: a head without tail locks, a tail releases and moves priority past the sender.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (state_q == S_IDLE) begin
      if (xfer) begin
        if (xfer_tail) begin
          ptr_d = winner + port_idx_t'(1);
        end else begin
          state_d = S_LOCKED;
          owner_d = winner;
        end
      end
    end else begin
      if (xfer && xfer_tail) begin
        state_d = S_IDLE;
        ptr_d   = owner_q + port_idx_t'(1);
      end
    end
  end

  // Credit counter: grant consumes a slot, credit_in returns one; a return into a full counter is flagged.
  always_comb begin
    credit_d = credit_q;
    cred_ovf = 1'b0;
    if (xfer && !credit_in) begin
      credit_d = credit_q - CW'(1);
    end else if (credit_in && !xfer) begin
      if (credit_q == CW'(CREDITS)) cred_ovf = 1'b1;
      else                          credit_d = credit_q + CW'(1);
    end
  end

  // State registers with synchronous reset to idle, pointer 0, full credits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      ptr_q    <= '0;
      credit_q <= CW'(CREDITS);
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

endmodule

// File: rtl/sw_alloc.sv
// Central 4x4 switch allocator driving crossbar grant vectors and input-buffer acks.
// Latency: ack/grant combinational (0 cycles); lock, pointer and credit state update next edge.
// Backpressure: per-output credits toward downstream; inputs see ack=0 until granted.
module sw_alloc
  import sw_pkg::*;
#(
  parameter int CREDITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NPORT-1:0] req0,
  input  logic [NPORT-1:0] req1,
  input  logic [NPORT-1:0] req2,
  input  logic [NPORT-1:0] req3,
  input  logic [NPORT-1:0] tail,
  input  logic [NPORT-1:0] credit_in,
  output logic [NPORT-1:0] ack,
  output logic [NPORT-1:0] grant0,
  output logic [NPORT-1:0] grant1,
  output logic [NPORT-1:0] grant2,
  output logic [NPORT-1:0] grant3,
  output logic [NPORT-1:0] locked,
  output logic             err
);

  portvec_t req_arr   [NPORT];
  portvec_t cand      [NPORT];
  portvec_t grant_arr [NPORT];
  logic [NPORT-1:0] ovf;
  logic             multi_hot;
  logic             err_q, err_d;

  // Clean multi-hot requests down to their lowest output, then transpose input-major to output-major.
  always_comb begin
    req_arr[0] = lowest_bit(req0);
    req_arr[1] = lowest_bit(req1);
    req_arr[2] = lowest_bit(req2);
    req_arr[3] = lowest_bit(req3);
    multi_hot  = is_multi_hot(req0) | is_multi_hot(req1) |
                 is_multi_hot(req2) | is_multi_hot(req3);
    for (int o = 0; o < NPORT; o++) begin
      cand[o] = '0;
      for (int i = 0; i < NPORT; i++) cand[o][i] = req_arr[i][o];
    end
  end

  for (genvar o = 0; o < NPORT; o++) begin : g_out
    sw_alloc_out #(.CREDITS(CREDITS)) u_out (
      .clk       (clk),
      .rst       (rst),
      .cand      (cand[o]),
      .tail      (tail),
      .credit_in (credit_in[o]),
      .grant     (grant_arr[o]),
      .locked    (locked[o]),
      .cred_ovf  (ovf[o])
    );
  end

  // Each input is popped when any output grants it; one-hot requests keep this to one grant per input.
  always_comb begin
    ack = '0;
    for (int o = 0; o < NPORT; o++) ack = ack | grant_arr[o];
    grant0 = grant_arr[0];
    grant1 = grant_arr[1];
    grant2 = grant_arr[2];
    grant3 = grant_arr[3];
    err_d  = err_q | (|ovf) | multi_hot;
    err    = err_q;
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

endmodule

// File: tb/tb_sw_alloc.sv
module tb_sw_alloc;
  import sw_pkg::*;

  logic     clk = 1'b0;
  logic     rst;
  portvec_t req0, req1, req2, req3, tail, credit_in;
  portvec_t ack, grant0, grant1, grant2, grant3, locked;
  logic     err;

  int n_tests = 0;
  int n_fail  = 0;

  portvec_t rot_exp [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  portvec_t drn_exp [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0000};

  always #5 clk = ~clk;

  sw_alloc #(.CREDITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .req2      (req2),
    .req3      (req3),
    .tail      (tail),
    .credit_in (credit_in),
    .ack       (ack),
    .grant0    (grant0),
    .grant1    (grant1),
    .grant2    (grant2),
    .grant3    (grant3),
    .locked    (locked),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive after the falling edge, let combinational outputs settle.
  task automatic cyc(input logic r, input portvec_t r0, input portvec_t r1, input portvec_t r2,
                     input portvec_t r3, input portvec_t tl, input portvec_t ci);
    @(negedge clk);
    assert ($onehot0(r0) && $onehot0(r1) && $onehot0(r2) && $onehot0(r3));
    rst = r; req0 = r0; req1 = r1; req2 = r2; req3 = r3; tail = tl; credit_in = ci;
    #1;
  endtask

  initial begin
    rst = 1'b1; req0 = '0; req1 = '0; req2 = '0; req3 = '0; tail = '0; credit_in = '0;

    // ---- reset, then single-flit grant to o0
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 4'b0001, 0, 0, 0, 4'b0001, 0);
    check("rst_grant0", grant0, 4'b0000);
    check("rst_ack", ack, 4'b0000);
    check("rst_locked", locked, 4'b0000);
    cyc(0, 4'b0001, 0, 0, 0, 4'b0001, 0);
    check("t1_err", err, 1'b0);
    check("t1_grant0", grant0, 4'b0001);
    check("t1_ack", ack, 4'b0001);
    check("t1_locked", locked, 4'b0000);

    // ---- all inputs to o0, single-flit, credit returned each cycle: rotate from ptr=1
    for (int k = 0; k < 5; k++) begin
      cyc(0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1111, 4'b0001);
      check($sformatf("t2_rot%0d", k), grant0, rot_exp[k]);
      check($sformatf("t2_ack%0d", k), ack, rot_exp[k]);
    end
    // credit(o0) is 3 here: three more grants, then stall
    for (int k = 0; k < 4; k++) begin
      cyc(0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1111, 0);
      check($sformatf("t2_drain%0d", k), grant0, drn_exp[k]);
    end

    // ---- 3-flit packet from input 2 to o1 while input 0 also wants o1
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 4'b0010, 0, 0, 0);
    check("t3_head_grant1", grant1, 4'b0100);
    check("t3_head_locked", locked, 4'b0000);
    cyc(0, 4'b0010, 0, 4'b0010, 0, 0, 0);
    check("t3_body_grant1", grant1, 4'b0100);
    check("t3_body_ack", ack, 4'b0100);
    check("t3_body_locked", locked, 4'b0010);
    cyc(0, 4'b0010, 0, 0, 0, 0, 0);
    check("t3_gap_grant1", grant1, 4'b0000);
    check("t3_gap_locked", locked, 4'b0010);
    cyc(0, 4'b0010, 0, 4'b0010, 0, 4'b0100, 0);
    check("t3_tail_grant1", grant1, 4'b0100);
    check("t3_tail_locked", locked, 4'b0010);
    cyc(0, 4'b0010, 0, 0, 0, 4'b0001, 0);
    check("t3_next_grant1", grant1, 4'b0001);
    check("t3_next_ack", ack, 4'b0001);
    check("t3_next_locked", locked, 4'b0000);

    // ---- credit exhaustion on o3
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 4'b1000, 0, 0, 0, 4'b0001, 0);
      check($sformatf("t4_ack%0d", k), ack, (k < 4) ? 4'b0001 : 4'b0000);
      check($sformatf("t4_grant3_%0d", k), grant3, (k < 4) ? 4'b0001 : 4'b0000);
    end
    cyc(0, 4'b1000, 0, 0, 0, 4'b0001, 4'b1000);
    check("t4_ret_ack", ack, 4'b0000);
    cyc(0, 4'b1000, 0, 0, 0, 4'b0001, 0);
    check("t4_one_ack", ack, 4'b0001);
    cyc(0, 4'b1000, 0, 0, 0, 4'b0001, 0);
    check("t4_after_ack", ack, 4'b0000);

    // ---- simultaneous grant + credit_in on o2, then overflow
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 4'b0100, 0, 0, 4'b0010, 0);
    cyc(0, 0, 4'b0100, 0, 0, 4'b0010, 0);
    cyc(0, 0, 4'b0100, 0, 0, 4'b0010, 4'b0100);
    check("t5_both_grant2", grant2, 4'b0010);
    cyc(0, 0, 4'b0100, 0, 0, 4'b0010, 0);
    check("t5_c2_grant2", grant2, 4'b0010);
    cyc(0, 0, 4'b0100, 0, 0, 4'b0010, 0);
    check("t5_c1_grant2", grant2, 4'b0010);
    cyc(0, 0, 4'b0100, 0, 0, 4'b0010, 0);
    check("t5_c0_grant2", grant2, 4'b0000);
    check("t5_err_pre", err, 1'b0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 0, 0, 4'b0100);
    check("t5_err_full", err, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 4'b0100);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("t5_err_set", err, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("t5_err_sticky", err, 1'b1);

    // ---- reset while o1 is locked to input 3
    cyc(0, 0, 0, 0, 4'b0010, 0, 0);
    check("t6_head_grant1", grant1, 4'b1000);
    cyc(0, 0, 0, 0, 4'b0010, 0, 0);
    check("t6_locked", locked, 4'b0010);
    cyc(1, 4'b0010, 0, 0, 0, 0, 0);
    check("t6_rst_grant1", grant1, 4'b0000);
    check("t6_rst_locked", locked, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 4'b0010, 0, 0, 0, 0, 0);
      check($sformatf("t6_grant1_%0d", k), grant1, (k < 4) ? 4'b0001 : 4'b0000);
      if (k == 0) begin
        check("t6_post_locked", locked, 4'b0000);
        check("t6_post_err", err, 1'b0);
      end
    end
    check("t6_relock", locked, 4'b0010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
